// File: rtl/i2c_aud_codec_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_aud_codec_slave_if
// Description : I2C bus pins and register-mirror signals of the audio codec
//               control-port responder.
//               slave  modport : the codec model (receives SCL/SDA, drives
//                                the open-drain enable and register outputs)
//               master modport : the bus master / system side
//   I2C_SCLK     bus clock from master
//   I2C_SDAT_IN  data as seen on the pad
//   I2C_SDAT_OE  1 = pull SDA low (never drives high)
//   o_REG_WE     one-cycle write strobe
//   o_REG_ADDR   register address of last write (7 bits)
//   o_REG_DATA   data of last write (9 bits)
//   iRD_ADDR     register-file read index (4 bits)
//   oRD_DATA     combinational read data (9 bits)
//   o_ACTIVE     R9[0]
//   o_BUSY       high from START until STOP
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_aud_codec_slave_if;
    logic       I2C_SCLK;
    logic       I2C_SDAT_IN;
    logic       I2C_SDAT_OE;
    logic       o_REG_WE;
    logic [6:0] o_REG_ADDR;
    logic [8:0] o_REG_DATA;
    logic [3:0] iRD_ADDR;
    logic [8:0] oRD_DATA;
    logic       o_ACTIVE;
    logic       o_BUSY;

    modport slave (
        input  I2C_SCLK, I2C_SDAT_IN, iRD_ADDR,
        output I2C_SDAT_OE, o_REG_WE, o_REG_ADDR, o_REG_DATA,
               oRD_DATA, o_ACTIVE, o_BUSY
    );

    modport master (
        output I2C_SCLK, I2C_SDAT_IN, iRD_ADDR,
        input  I2C_SDAT_OE, o_REG_WE, o_REG_ADDR, o_REG_DATA,
               oRD_DATA, o_ACTIVE, o_BUSY
    );
endinterface
`default_nettype wire

// File: rtl/i2c_aud_codec_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_aud_codec_slave
// Description : Write-only I2C responder modelling an audio codec control
//               port. Accepts 3-byte writes [addr, {reg[6:0],d[8]}, d[7:0]],
//               ACKs them and keeps a ten-entry 9-bit register file.
// Ports       : iCLK    system clock (>= 16x SCL rate)
//               iRST_N  synchronous active-low reset
//               bus     i2c_aud_codec_slave_if.slave (I2C pins, write strobe,
//                       read port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_aud_codec_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter int         FILT_LEN   = 4
) (
    input  wire logic iCLK,
    input  wire logic iRST_N,
    i2c_aud_codec_slave_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        ADDR          = 4'd1,
        ADDR_ACK      = 4'd2,
        HI_BYTE       = 4'd3,
        HI_ACK        = 4'd4,
        LO_BYTE       = 4'd5,
        LO_ACK        = 4'd6,
        LO_BYTE_EXTRA = 4'd7,
        IGNORE        = 4'd8
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);
    localparam logic [8:0] REG_DEFAULT [10] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    // ---------------- input synchroniser + glitch filter --------------------
    // Index 0 = SCL, index 1 = SDA.
    logic [1:0] raw;
    logic [1:0] filt;
    assign raw = {bus.I2C_SDAT_IN, bus.I2C_SCLK};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic       s1;
        logic       s2;
        logic       f;
        logic [3:0] cnt;

        // The filtered level only moves once the synchronised input has
        // disagreed with it for FILT_LEN consecutive samples.
        always_ff @(posedge iCLK) begin
            if (!iRST_N) begin
                s1  <= 1'b1;
                s2  <= 1'b1;
                f   <= 1'b1;
                cnt <= 4'd0;
            end else begin
                s1 <= raw[g];
                s2 <= s1;
                if (s2 == f) begin
                    cnt <= 4'd0;
                end else if (cnt == CNT_MAX) begin
                    f   <= s2;
                    cnt <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
        assign filt[g] = f;
    end

    logic scl_f, sda_f, scl_prev, sda_prev;
    assign scl_f = filt[0];
    assign sda_f = filt[1];

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f &  scl_prev;
    assign start_det = ~sda_f &  sda_prev & scl_f;
    assign stop_det  =  sda_f & ~sda_prev & scl_f;

    // ---------------- protocol FSM ----------------------------------------
    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] shift, shift_n;
    logic [7:0] hi, hi_n;
    logic       ack_ph, ack_ph_n;   // 0: waiting to drive ACK, 1: ACK driven
    logic       oe, oe_n;
    logic       we, we_n;
    logic [6:0] waddr, waddr_n;
    logic [8:0] wdata, wdata_n;
    logic [7:0] byte_full;

    assign byte_full = {shift, sda_f};

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
            hi      <= 8'd0;
            ack_ph  <= 1'b0;
            oe      <= 1'b0;
            we      <= 1'b0;
            waddr   <= 7'd0;
            wdata   <= 9'd0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            hi      <= hi_n;
            ack_ph  <= ack_ph_n;
            oe      <= oe_n;
            we      <= we_n;
            waddr   <= waddr_n;
            wdata   <= wdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        hi_n      = hi;
        ack_ph_n  = ack_ph;
        oe_n      = oe;
        we_n      = 1'b0;
        waddr_n   = waddr;
        wdata_n   = wdata;

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            oe_n      = 1'b0;
            ack_ph_n  = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            oe_n      = 1'b0;
            ack_ph_n  = 1'b0;
        end else begin
            case (state)
                ADDR, HI_BYTE, LO_BYTE, LO_BYTE_EXTRA: begin
                    if (scl_rise) begin
                        shift_n = byte_full[6:0];
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n = 3'd0;
                            case (state)
                                ADDR:    state_n = (byte_full == {SLAVE_ADDR, 1'b0})
                                                   ? ADDR_ACK : IGNORE;
                                HI_BYTE: begin
                                    hi_n    = byte_full;
                                    state_n = HI_ACK;
                                end
                                LO_BYTE: begin
                                    we_n    = 1'b1;
                                    waddr_n = hi[7:1];
                                    wdata_n = {hi[0], byte_full};
                                    state_n = LO_ACK;
                                end
                                default: state_n = IGNORE;  // surplus byte: NACK
                            endcase
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                ADDR_ACK, HI_ACK, LO_ACK: begin
                    // First SCL fall after the 8th bit drives ACK, the next
                    // one (end of the 9th clock) releases it.
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            oe_n     = 1'b1;
                            ack_ph_n = 1'b1;
                        end else begin
                            oe_n     = 1'b0;
                            ack_ph_n = 1'b0;
                            case (state)
                                ADDR_ACK: state_n = HI_BYTE;
                                HI_ACK:   state_n = LO_BYTE;
                                default:  state_n = LO_BYTE_EXTRA;
                            endcase
                        end
                    end
                end
                default: ;  // IDLE / IGNORE wait for START or STOP
            endcase
        end
    end

    // ---------------- register file -----------------------------------------
    logic [8:0] regs [10];

    always_ff @(posedge iCLK) begin
        if (!iRST_N || (we_n && waddr_n == 7'h0F)) begin
            for (int i = 0; i < 10; i++) regs[i] <= REG_DEFAULT[i];
        end else if (we_n) begin
            for (int i = 0; i < 10; i++) begin
                if (waddr_n == 7'(i)) regs[i] <= wdata_n;
            end
        end
    end

    assign bus.oRD_DATA    = (bus.iRD_ADDR < 4'd10) ? regs[bus.iRD_ADDR] : 9'd0;
    assign bus.o_ACTIVE    = regs[9][0];
    assign bus.o_BUSY      = (state != IDLE);
    assign bus.I2C_SDAT_OE = oe;
    assign bus.o_REG_WE    = we;
    assign bus.o_REG_ADDR  = waddr;
    assign bus.o_REG_DATA  = wdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_aud_codec_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_aud_codec_slave
// Description : Directed self-checking bench for i2c_aud_codec_slave. Acts as
//               an open-drain I2C master and checks ACKs, write strobes and
//               register-file contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_aud_codec_slave;

    localparam int QP = 10;   // quarter SCL period in iCLK cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    logic [3:0] rd_addr = 4'd0;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    i2c_aud_codec_slave_if bus ();

    assign bus.I2C_SCLK    = scl;
    assign bus.I2C_SDAT_IN = m_sda & ~bus.I2C_SDAT_OE;   // wired-AND bus
    assign bus.iRD_ADDR    = rd_addr;

    i2c_aud_codec_slave #(.SLAVE_ADDR(7'h1A), .FILT_LEN(4)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always @(negedge clk) begin
        if (bus.o_REG_WE)    we_cnt <= we_cnt + 1;
        if (bus.I2C_SDAT_OE) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [8:0] exp, input string tag);
        rd_addr = a;
        #1;
        chk(tag, {7'd0, bus.oRD_DATA}, {7'd0, exp});
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; w(QP);
        scl   = 1'b1; w(QP);
        m_sda = 1'b0; w(QP);
        scl   = 1'b0; w(QP);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; w(QP);
        scl   = 1'b1; w(QP);
        m_sda = 1'b1; w(2*QP);
    endtask

    // gs: SCL high glitch length during low phase; gd: SDA glitch during high phase
    task automatic send_bits(input logic [7:0] b, input int gs, input int gd);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            if (gs > 0) begin
                w(2); scl = 1'b1; w(gs); scl = 1'b0; w(QP - 2 - gs);
            end else begin
                w(QP);
            end
            scl = 1'b1;
            if (gd > 0) begin
                w(3); m_sda = ~m_sda; w(gd); m_sda = ~m_sda; w(2*QP - 3 - gd);
            end else begin
                w(2*QP);
            end
            scl = 1'b0;
            w(QP);
        end
    endtask

    task automatic ack_phase(output logic ack);
        m_sda = 1'b1; w(QP);
        scl   = 1'b1; w(QP);
        ack   = bus.I2C_SDAT_IN === 1'b0;
        w(QP);
        scl   = 1'b0; w(QP);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int gs, input int gd, output logic ack);
        send_bits(b, gs, gd);
        ack_phase(ack);
    endtask

    task automatic xfer3(input logic [7:0] b0, b1, b2, output logic [2:0] acks);
        i2c_start;
        wr_byte(b0, 0, 0, acks[2]);
        wr_byte(b1, 0, 0, acks[1]);
        wr_byte(b2, 0, 0, acks[0]);
        i2c_stop;
    endtask

    logic [2:0] acks;
    logic       a0, a1, a2;
    int         we0, oe0;

    initial begin
        // ---- reset state ----
        w(5);
        chk("rst_oe",   {15'd0, bus.I2C_SDAT_OE}, 16'd0);
        chk("rst_we",   {15'd0, bus.o_REG_WE},    16'd0);
        chk("rst_addr", {9'd0, bus.o_REG_ADDR},   16'd0);
        chk("rst_data", {7'd0, bus.o_REG_DATA},   16'd0);
        chk("rst_busy", {15'd0, bus.o_BUSY},      16'd0);
        rst_n = 1'b1;
        w(10);
        rd(4'd0,  9'h097, "def_r0");
        rd(4'd4,  9'h00A, "def_r4");
        rd(4'd6,  9'h09F, "def_r6");
        rd(4'd12, 9'h000, "rd_oob");
        chk("def_active", {15'd0, bus.o_ACTIVE}, 16'd0);

        // ---- write R4 = 012 ----
        we0 = we_cnt;
        xfer3(8'h34, 8'h08, 8'h12, acks);
        chk("r4_acks",  {13'd0, acks},           16'h7);
        chk("r4_we",    16'(we_cnt - we0),       16'd1);
        chk("r4_addr",  {9'd0, bus.o_REG_ADDR},  16'h04);
        chk("r4_data",  {7'd0, bus.o_REG_DATA},  16'h012);
        rd(4'd4, 9'h012, "r4_val");
        chk("r4_busy",  {15'd0, bus.o_BUSY},     16'd0);

        // ---- R9 = 001 -> active ----
        xfer3(8'h34, 8'h12, 8'h01, acks);
        chk("r9_acks",  {13'd0, acks},           16'h7);
        chk("r9_active",{15'd0, bus.o_ACTIVE},   16'd1);

        // ---- reset register 0x0F ----
        we0 = we_cnt;
        xfer3(8'h34, 8'h1E, 8'h00, acks);
        chk("rr_acks",  {13'd0, acks},           16'h7);
        chk("rr_we",    16'(we_cnt - we0),       16'd1);
        chk("rr_addr",  {9'd0, bus.o_REG_ADDR},  16'h0F);
        rd(4'd4, 9'h00A, "rr_r4");
        chk("rr_active",{15'd0, bus.o_ACTIVE},   16'd0);

        // ---- wrong address and read request are ignored ----
        we0 = we_cnt; oe0 = oe_cnt;
        xfer3(8'h36, 8'h08, 8'h12, acks);
        i2c_start;
        wr_byte(8'h35, 0, 0, a0);
        i2c_stop;
        chk("bad_acks", {13'd0, acks},           16'h0);
        chk("rd_nack",  {15'd0, a0},             16'd0);
        chk("bad_oe",   16'(oe_cnt - oe0),       16'd0);
        chk("bad_we",   16'(we_cnt - we0),       16'd0);
        rd(4'd4, 9'h00A, "bad_r4");

        // ---- truncated write: addr + hi then STOP ----
        we0 = we_cnt;
        i2c_start;
        chk("busy_mid", {15'd0, bus.o_BUSY},     16'd1);
        wr_byte(8'h34, 0, 0, a0);
        wr_byte(8'h0A, 0, 0, a1);
        i2c_stop;
        chk("tr_acks",  {14'd0, a0, a1},         16'h3);
        chk("tr_we",    16'(we_cnt - we0),       16'd0);
        chk("tr_busy",  {15'd0, bus.o_BUSY},     16'd0);
        rd(4'd5, 9'h008, "tr_r5");

        // ---- repeated START after hi byte ----
        we0 = we_cnt;
        i2c_start;
        wr_byte(8'h34, 0, 0, a0);
        wr_byte(8'h0A, 0, 0, a0);
        i2c_start;
        wr_byte(8'h34, 0, 0, a0);
        wr_byte(8'h0E, 0, 0, a1);
        wr_byte(8'h01, 0, 0, a2);
        i2c_stop;
        chk("rs_acks",  {13'd0, a0, a1, a2},     16'h7);
        chk("rs_we",    16'(we_cnt - we0),       16'd1);
        rd(4'd7, 9'h001, "rs_r7");
        rd(4'd5, 9'h008, "rs_r5");

        // ---- surplus byte is NACKed ----
        i2c_start;
        wr_byte(8'h34, 0, 0, a0);
        wr_byte(8'h08, 0, 0, a0);
        wr_byte(8'h33, 0, 0, a1);
        wr_byte(8'h55, 0, 0, a2);
        i2c_stop;
        chk("ex_acks",  {13'd0, a0, a1, a2},     16'h6);
        rd(4'd4, 9'h033, "ex_r4");

        // ---- glitches of 1 and FILT_LEN-1 cycles ----
        we0 = we_cnt;
        i2c_start;
        wr_byte(8'h34, 0, 0, a0);
        wr_byte(8'h0C, 1, 1, a1);
        wr_byte(8'h44, 3, 3, a2);
        i2c_stop;
        chk("gl_acks",  {13'd0, a0, a1, a2},     16'h7);
        chk("gl_we",    16'(we_cnt - we0),       16'd1);
        rd(4'd6, 9'h044, "gl_r6");

        // ---- reset while ACK is driven in HI_ACK ----
        i2c_start;
        wr_byte(8'h34, 0, 0, a0);
        send_bits(8'h08, 0, 0);
        chk("ra_oe1",   {15'd0, bus.I2C_SDAT_OE}, 16'd1);
        rst_n = 1'b0;
        w(1);
        chk("ra_oe0",   {15'd0, bus.I2C_SDAT_OE}, 16'd0);
        chk("ra_busy",  {15'd0, bus.o_BUSY},      16'd0);
        rd(4'd4, 9'h00A, "ra_r4");
        rd(4'd6, 9'h09F, "ra_r6");
        m_sda = 1'b1;
        scl   = 1'b1;
        w(3);
        rst_n = 1'b1;
        w(20);
        xfer3(8'h34, 8'h08, 8'h12, acks);
        chk("ra_acks",  {13'd0, acks},           16'h7);
        rd(4'd4, 9'h012, "ra_r4b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
